// File: rtl/md_sched.sv
// Multiply/divide scheduler beside the E-stage ALU; owns HI/LO. Optional MD_DIVZ_EN: 1-cycle divide-by-zero with sticky divz.
// Latency: MULT_CYCLES/DIV_CYCLES busy cycles after the accepting edge; mthi/mtlo write on the next edge.
// Backpressure: stall_md holds a D-stage md instruction while busy or while an op is being started.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        divz
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;

  logic        is_div, is_uns, a_neg, b_neg, b_zero;
  logic [63:0] ext_a, ext_b, prod;
  logic [31:0] mag_a, mag_b, div_b, quo_m, rem_m, quo, rem;
  logic [63:0] res;

  // Divide works on magnitudes so the 0x80000000 / -1 case never overflows.
  always_comb begin
    is_div = op_q[1];
    is_uns = op_q[0];
    ext_a  = is_uns ? {32'b0, a_q} : {{32{a_q[31]}}, a_q};
    ext_b  = is_uns ? {32'b0, b_q} : {{32{b_q[31]}}, b_q};
    prod   = ext_a * ext_b;
    a_neg  = ~is_uns & a_q[31];
    b_neg  = ~is_uns & b_q[31];
    mag_a  = a_neg ? (32'd0 - a_q) : a_q;
    mag_b  = b_neg ? (32'd0 - b_q) : b_q;
    b_zero = (b_q == 32'd0);
    div_b  = b_zero ? 32'd1 : mag_b;
    quo_m  = mag_a / div_b;
    rem_m  = mag_a % div_b;
    quo    = (a_neg ^ b_neg) ? (32'd0 - quo_m) : quo_m;
    rem    = a_neg ? (32'd0 - rem_m) : rem_m;
    if (!is_div)     res = prod;
    else if (b_zero) res = {a_q, 32'hFFFF_FFFF};
    else             res = {rem, quo};
  end

`ifdef MD_DIVZ_EN
  logic divz_q, divz_d;
  assign divz = divz_q;
`else
  assign divz = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MD_DIVZ_EN
    divz_d  = divz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!op[2]) begin
            a_d     = a;
            b_d     = b;
            op_d    = op[1:0];
            cnt_d   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
`ifdef MD_DIVZ_EN
            if (op[1] && (b == 32'd0)) cnt_d = CW'(1);
`endif
            state_d = S_BUSY;
          end else if (op == 3'd4) begin
            hi_d = a;
          end else if (op == 3'd5) begin
            lo_d = a;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
`ifdef MD_DIVZ_EN
          if (is_div && b_zero) divz_d = 1'b1;
          else {hi_d, lo_d} = res;
`else
          {hi_d, lo_d} = res;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MD_DIVZ_EN
      divz_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MD_DIVZ_EN
      divz_q  <= divz_d;
`endif
    end
  end

  assign busy     = (state_q == S_BUSY);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign stall_md = md_use_d & (busy | (start & ~op[2]));

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: mult/div results, busy timing, stall_md, mthi/mtlo, async reset, divide-by-zero.
module tb_md_sched;
  logic        clk = 1'b0;
  logic        reset, start, md_use_d;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, stall_md, divz;
  logic [31:0] hi, lo;
  int          vecs = 0;
  int          errs = 0;

  always #5 clk = ~clk;

  md_sched dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .md_use_d(md_use_d), .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo), .divz(divz)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb);
    start = 1'b1; op = o; a = aa; b = bb;
    #1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0; md_use_d = 1'b0;
    step(2);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_divz", {31'b0, divz}, 32'd0);
    chk("rst_stall", {31'b0, stall_md}, 32'd0);
    reset = 1'b1;
    step(1);

    // signed mult with D-stage md instruction waiting
    md_use_d = 1'b1;
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    chk("mult_stall_start", {31'b0, stall_md}, 32'd1);
    chk("mult_busy_start", {31'b0, busy}, 32'd0);
    step(1);
    start = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      chk("mult_busy", {31'b0, busy}, 32'd1);
      chk("mult_stall", {31'b0, stall_md}, 32'd1);
      chk("mult_hi_hold", hi, 32'd0);
      step(1);
    end
    chk("mult_busy_done", {31'b0, busy}, 32'd0);
    chk("mult_stall_done", {31'b0, stall_md}, 32'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    md_use_d = 1'b0;

    // signed divide, no stall without a D-stage md instruction
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_stall_start", {31'b0, stall_md}, 32'd0);
    step(1);
    start = 1'b0; #1;
    for (int i = 0; i < 10; i++) begin
      chk("div_busy", {31'b0, busy}, 32'd1);
      chk("div_stall", {31'b0, stall_md}, 32'd0);
      step(1);
    end
    chk("div_busy_done", {31'b0, busy}, 32'd0);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // unsigned divide; an mthi raised on the completing cycle must be dropped
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    step(1);
    start = 1'b0; #1;
    for (int i = 0; i < 10; i++) begin
      chk("divu_busy", {31'b0, busy}, 32'd1);
      if (i == 9) begin
        start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
      end
      step(1);
    end
    start = 1'b0; #1;
    chk("divu_busy_done", {31'b0, busy}, 32'd0);
    chk("divu_lo", lo, 32'h7FFF_FFFC);
    chk("divu_hi", hi, 32'd1);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    step(1);
    start = 1'b0;
    step(10);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(1);
    start = 1'b0;
    step(5);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    // mthi / mtlo / reserved op
    md_use_d = 1'b1;
    issue(3'd4, 32'h1234_5678, 32'd0);
    chk("mthi_stall", {31'b0, stall_md}, 32'd0);
    step(1);
    start = 1'b0; #1;
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    issue(3'd5, 32'h9ABC_DEF0, 32'd0);
    step(1);
    start = 1'b0; #1;
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    chk("mtlo_hi", hi, 32'h1234_5678);
    md_use_d = 1'b0;
    issue(3'd6, 32'h5555_5555, 32'd7);
    step(1);
    start = 1'b0; #1;
    chk("rsv_hi", hi, 32'h1234_5678);
    chk("rsv_lo", lo, 32'h9ABC_DEF0);
    chk("rsv_busy", {31'b0, busy}, 32'd0);

    // async reset in the middle of a mult
    issue(3'd0, 32'd2, 32'd3);
    step(1);
    start = 1'b0;
    step(2);
    chk("abort_busy_pre", {31'b0, busy}, 32'd1);
    reset = 1'b0; #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    step(2);
    reset = 1'b1;
    step(8);
    chk("abort_busy_after", {31'b0, busy}, 32'd0);
    chk("abort_hi_after", hi, 32'd0);
    chk("abort_lo_after", lo, 32'd0);

    // divide by zero
    issue(3'd4, 32'h11, 32'd0);
    step(1);
    issue(3'd5, 32'h22, 32'd0);
    step(1);
    issue(3'd2, 32'd5, 32'd0);
    step(1);
    start = 1'b0; #1;
`ifdef MD_DIVZ_EN
    chk("dz_busy", {31'b0, busy}, 32'd1);
    step(1);
    chk("dz_busy_done", {31'b0, busy}, 32'd0);
    chk("dz_hi", hi, 32'h11);
    chk("dz_lo", lo, 32'h22);
    chk("dz_flag", {31'b0, divz}, 32'd1);
`else
    for (int i = 0; i < 10; i++) begin
      chk("dz_busy", {31'b0, busy}, 32'd1);
      step(1);
    end
    chk("dz_busy_done", {31'b0, busy}, 32'd0);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    chk("dz_hi", hi, 32'd5);
    chk("dz_flag", {31'b0, divz}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
